dff_delay_line: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage chain of D registers.
- Carries a per-stage valid bit and supports advance-enable (stall), flush, and a run-time selectable output tap.
- Provides true and complement outputs, like the basic DFF.
- Used as a programmable pipeline delay and alignment element between datapath blocks.

---
 rtl/dff_delay_line.sv | 84 ++++++++
 tb/tb_dff_delay_line.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dff_delay_line.sv
// dff_delay_line: WIDTH-bit, DEPTH-stage chain of D registers with a valid
// bit per stage. Used as a programmable pipeline delay / alignment element.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (data <= RST_VAL, valids <= 0)
//   en        advance the chain by one stage this cycle
//   flush     clear every valid bit; data registers hold
//   d, d_vld  input sample and its valid, captured into stage 0 on advance
//   tap_sel   output tap; 0 = stage 0 (one cycle of delay), out-of-range
//             values saturate to the last stage
//   q, qb     data at the selected stage and its bitwise complement
//   q_vld     valid bit of the selected stage
//   last_q    data at stage DEPTH-1, independent of tap_sel
//   last_vld  valid bit of stage DEPTH-1
//   count     number of stages currently holding a valid sample
//
// Every output is driven from registers and tap_sel only; d, en and flush
// reach the outputs only through a clock edge.
module dff_delay_line #(
  parameter int                 WIDTH   = 8,
  parameter int                 DEPTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             q_vld,
  output logic [WIDTH-1:0] last_q,
  output logic             last_vld,
  output logic [CW-1:0]    count
);

  localparam logic [TW-1:0] LAST_IDX = TW'(DEPTH - 1);

  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic [TW-1:0]    k;

  // Priority: rst > flush > en > hold. Flush leaves data in place so the
  // data outputs stay stable; only the valids are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] <= RST_VAL;
      end
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (en) begin
      s[0] <= d;
      v[0] <= d_vld;
      for (int i = 1; i < DEPTH; i++) begin
        s[i] <= s[i-1];
        v[i] <= v[i-1];
      end
    end
  end

  // Saturate an out-of-range tap to the last stage. For DEPTH=1 any tap
  // value resolves to stage 0.
  always_comb begin
    k = LAST_IDX;
    if (32'(tap_sel) < DEPTH) begin
      k = tap_sel;
    end
  end

  assign q        = s[k];
  assign qb       = ~s[k];
  assign q_vld    = v[k];
  assign last_q   = s[DEPTH-1];
  assign last_vld = v[DEPTH-1];
  assign count    = CW'($countones(v));

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed bench for dff_delay_line: a DEPTH=4 instance for the main
// scenarios and a DEPTH=3 instance (sharing the control/data stream) for
// tap saturation.
module tb_dff_delay_line;

  logic       clk = 1'b0;
  logic       rst, en, flush, d_vld;
  logic [7:0] d;
  logic [1:0] tap_sel, tap_sel3;

  logic [7:0] q, qb, last_q;
  logic       q_vld, last_vld;
  logic [2:0] count;

  logic [7:0] q3, qb3, last_q3;
  logic       q_vld3, last_vld3;
  logic [1:0] count3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel), .q(q), .qb(qb), .q_vld(q_vld), .last_q(last_q),
    .last_vld(last_vld), .count(count)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel3), .q(q3), .qb(qb3), .q_vld(q_vld3), .last_q(last_q3),
    .last_vld(last_vld3), .count(count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_vld = 1'b1;
    tap_sel = 2'd0; tap_sel3 = 2'd0;
    tick();
    tick();
    n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL rst_q got=%h exp=%h", q, 8'h00); end
    n_cmp++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL rst_qb got=%h exp=%h", qb, 8'hFF); end
    n_cmp++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL rst_q_vld got=%b exp=0", q_vld); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (last_q !== 8'h00 || last_vld !== 1'b0) begin n_bad++; $display("FAIL rst_last got=%h/%b exp=00/0", last_q, last_vld); end
    rst = 1'b0; en = 1'b0;
    #1;
    n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL rst_deassert_q got=%h exp=00", q); end
    tick();
    n_cmp++; if (q !== 8'h00 || count !== 3'd0) begin n_bad++; $display("FAIL rst_hold got=%h/%0d exp=00/0", q, count); end
  endtask

  task automatic test_latency();
    en = 1'b1; d_vld = 1'b1; tap_sel = 2'd0;
    d = 8'h11; tick();
    n_cmp++; if (q !== 8'h11 || q_vld !== 1'b1) begin n_bad++; $display("FAIL lat_tap0 got=%h/%b exp=11/1", q, q_vld); end
    tap_sel = 2'd3;
    d = 8'h22; tick();
    d = 8'h33; tick();
    n_cmp++; if (q !== 8'h00 || q_vld !== 1'b0) begin n_bad++; $display("FAIL lat_tap3_early got=%h/%b exp=00/0", q, q_vld); end
    d = 8'h44; tick();
    n_cmp++; if (q !== 8'h11 || q_vld !== 1'b1) begin n_bad++; $display("FAIL lat_tap3 got=%h/%b exp=11/1", q, q_vld); end
    n_cmp++; if (last_q !== 8'h11) begin n_bad++; $display("FAIL lat_last_q got=%h exp=11", last_q); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL lat_count got=%0d exp=4", count); end
    en = 1'b0;
    tap_sel = 2'd1;
    #1;
    n_cmp++; if (q !== 8'h33 || qb !== 8'hCC) begin n_bad++; $display("FAIL lat_tap_switch got=%h/%h exp=33/cc", q, qb); end
  endtask

  task automatic test_stall();
    // chain [44,33,22,11] all valid; flush to start from count 0
    flush = 1'b1; tick(); flush = 1'b0;
    en = 1'b1; d_vld = 1'b1; tap_sel = 2'd1;
    d = 8'hA1; tick();
    d = 8'hA2; tick();
    // chain [A2,A1,44,33], valid [1,1,0,0]
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'hB0 + 8'(i);
      tick();
      n_cmp++; if (q !== 8'hA1 || count !== 3'd2) begin n_bad++; $display("FAIL stall_hold%0d got=%h/%0d exp=a1/2", i, q, count); end
    end
    en = 1'b1; d_vld = 1'b0;
    d = 8'hC1; tick();
    n_cmp++; if (last_q !== 8'h44 || last_vld !== 1'b0) begin n_bad++; $display("FAIL stall_resume1 got=%h/%b exp=44/0", last_q, last_vld); end
    d = 8'hC2; tick();
    n_cmp++; if (last_q !== 8'hA1 || last_vld !== 1'b1) begin n_bad++; $display("FAIL stall_resume2 got=%h/%b exp=a1/1", last_q, last_vld); end
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL stall_count got=%0d exp=2", count); end
    en = 1'b0;
  endtask

  task automatic test_flush();
    en = 1'b1; d_vld = 1'b1; tap_sel = 2'd1;
    d = 8'hD1; tick();
    d = 8'hD2; tick();
    d = 8'hD3; tick();
    d = 8'hD4; tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL flush_full got=%0d exp=4", count); end
    flush = 1'b1; d = 8'h55; d_vld = 1'b1;
    tick();
    flush = 1'b0; en = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_cmp++; if (q_vld !== 1'b0 || last_vld !== 1'b0) begin n_bad++; $display("FAIL flush_vld got=%b/%b exp=0/0", q_vld, last_vld); end
    n_cmp++; if (q !== 8'hD3 || last_q !== 8'hD1) begin n_bad++; $display("FAIL flush_data got=%h/%h exp=d3/d1", q, last_q); end
    tap_sel = 2'd0;
    #1;
    n_cmp++; if (q !== 8'hD4) begin n_bad++; $display("FAIL flush_nocapture got=%h exp=d4", q); end
  endtask

  task automatic test_priority_sat();
    en = 1'b1; d_vld = 1'b1; d = 8'h77; tap_sel = 2'd0;
    tick();
    n_cmp++; if (q !== 8'h77 || count !== 3'd1) begin n_bad++; $display("FAIL prio_load got=%h/%0d exp=77/1", q, count); end
    rst = 1'b1; flush = 1'b1; en = 1'b1; d = 8'h99;
    tick();
    rst = 1'b0; flush = 1'b0;
    n_cmp++; if (q !== 8'h00 || qb !== 8'hFF || count !== 3'd0) begin n_bad++; $display("FAIL prio_rst got=%h/%h/%0d exp=00/ff/0", q, qb, count); end
    n_cmp++; if (last_q !== 8'h00 || count3 !== 2'd0) begin n_bad++; $display("FAIL prio_rst_last got=%h/%0d exp=00/0", last_q, count3); end
    en = 1'b1; d_vld = 1'b1;
    d = 8'hE1; tick();
    d = 8'hE2; tick();
    d = 8'hE3; tick();
    en = 1'b0;
    // DEPTH=3 chain [E3,E2,E1]
    tap_sel3 = 2'd2; #1;
    n_cmp++; if (q3 !== 8'hE1 || q_vld3 !== 1'b1) begin n_bad++; $display("FAIL sat_tap2 got=%h/%b exp=e1/1", q3, q_vld3); end
    tap_sel3 = 2'd3; #1;
    n_cmp++; if (q3 !== 8'hE1 || q3 !== last_q3 || q_vld3 !== 1'b1) begin n_bad++; $display("FAIL sat_tap3 got=%h/%h/%b exp=e1/e1/1", q3, last_q3, q_vld3); end
    tap_sel3 = 2'd1; #1;
    n_cmp++; if (q3 !== 8'hE2) begin n_bad++; $display("FAIL sat_tap1 got=%h exp=e2", q3); end
    n_cmp++; if (count3 !== 2'd3 || count !== 3'd3) begin n_bad++; $display("FAIL sat_count got=%0d/%0d exp=3/3", count3, count); end
  endtask

  task automatic test_bubbles();
    logic [7:0] dv [4];
    logic       vv [4];
    dv[0] = 8'h01; dv[1] = 8'h02; dv[2] = 8'h03; dv[3] = 8'h04;
    vv[0] = 1'b1;  vv[1] = 1'b0;  vv[2] = 1'b1;  vv[3] = 1'b0;
    en = 1'b1; tap_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      d = dv[i]; d_vld = vv[i];
      tick();
      n_cmp++; if (q !== dv[i] || q_vld !== vv[i]) begin n_bad++; $display("FAIL bub_tap0_%0d got=%h/%b exp=%h/%b", i, q, q_vld, dv[i], vv[i]); end
    end
    en = 1'b0;
    // chain [04,03,02,01], valid [0,1,0,1]
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL bub_count got=%0d exp=2", count); end
    n_cmp++; if (last_vld !== 1'b1 || last_q !== 8'h01) begin n_bad++; $display("FAIL bub_last got=%h/%b exp=01/1", last_q, last_vld); end
    tap_sel = 2'd1; #1;
    n_cmp++; if (q !== 8'h03 || q_vld !== 1'b1) begin n_bad++; $display("FAIL bub_tap1 got=%h/%b exp=03/1", q, q_vld); end
    tap_sel = 2'd2; #1;
    n_cmp++; if (q !== 8'h02 || q_vld !== 1'b0) begin n_bad++; $display("FAIL bub_tap2 got=%h/%b exp=02/0", q, q_vld); end
    tap_sel = 2'd3; #1;
    n_cmp++; if (q !== 8'h01 || q_vld !== 1'b1) begin n_bad++; $display("FAIL bub_tap3 got=%h/%b exp=01/1", q, q_vld); end
    n_cmp++; if (count3 !== 2'd1 || last_q3 !== 8'h02) begin n_bad++; $display("FAIL bub_d3 got=%0d/%h exp=1/02", count3, last_q3); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_vld = 1'b0;
    tap_sel = 2'd0; tap_sel3 = 2'd0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_priority_sat();
    test_bubbles();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
